// File: rtl/axis_fifo_pkt.sv
// Parametrised AXI4-Stream synchronous FIFO with occupancy/almost flags and an
// optional store-and-forward packet mode that holds output until a full packet is buffered.
module axis_fifo_pkt #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0,
    parameter int AF_THRESH   = DEPTH - 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic                       s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       pkt_oversize
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int OCC_W      = PTR_W + 1;
    localparam int ENTRY_W    = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
    localparam bit PKT = (PACKET_MODE != 0);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ_next;
    logic [OCC_W-1:0]   pkt_cnt;
    logic [OCC_W-1:0]   pkt_cnt_next;
    logic               ready_en;
    logic               rel_flag;
    logic               push;
    logic               pop;
    logic               oversize_hit;

    // ready_en keeps the input closed during reset and opens it on the first edge after release
    assign s_axis_tready = ready_en && (occupancy != FULL_OCC);
    assign m_axis_tvalid = (occupancy != '0) && (!PKT || (pkt_cnt != '0) || rel_flag);
    assign push          = s_axis_tvalid && s_axis_tready;
    assign pop           = m_axis_tvalid && m_axis_tready;

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = mem[rd_ptr];

    // A full buffer with no complete packet can never drain on its own, so force release
    assign oversize_hit = PKT && (occupancy == FULL_OCC) && (pkt_cnt == '0) && !rel_flag;

    always_comb begin
        occ_next     = occupancy;
        pkt_cnt_next = pkt_cnt;
        if (push && !pop) begin
            occ_next = occupancy + 1'b1;
        end else if (pop && !push) begin
            occ_next = occupancy - 1'b1;
        end
        if ((push && s_axis_tlast) && !(pop && m_axis_tlast)) begin
            pkt_cnt_next = pkt_cnt + 1'b1;
        end else if ((pop && m_axis_tlast) && !(push && s_axis_tlast)) begin
            pkt_cnt_next = pkt_cnt - 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupancy    <= '0;
            pkt_cnt      <= '0;
            ready_en     <= 1'b0;
            rel_flag     <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            pkt_oversize <= 1'b0;
        end else begin
            ready_en     <= 1'b1;
            occupancy    <= occ_next;
            pkt_cnt      <= pkt_cnt_next;
            almost_full  <= (int'(occ_next) >= AF_THRESH);
            almost_empty <= (int'(occ_next) <= AE_THRESH);
            pkt_oversize <= oversize_hit;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (oversize_hit) begin
                rel_flag <= 1'b1;
            end else if (pop && m_axis_tlast) begin
                rel_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
        end
    end

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Self-checking bench for axis_fifo_pkt: one cut-through instance (index 0) and one
// packet-mode instance (index 1), scored against per-instance expected-beat queues.
module tb_axis_fifo_pkt;

    typedef struct packed {
        logic [7:0] data;
        logic [0:0] keep;
        logic       last;
    } beat_t;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       s_valid [2];
    logic       s_ready [2];
    logic [7:0] s_data  [2];
    logic [0:0] s_keep  [2];
    logic       s_last  [2];
    logic       m_valid [2];
    logic       m_ready [2];
    logic [7:0] m_data  [2];
    logic [0:0] m_keep  [2];
    logic       m_last  [2];
    logic [4:0] occ     [2];
    logic       af      [2];
    logic       ae      [2];
    logic       ovs     [2];

    beat_t q0[$];
    beat_t q1[$];
    int    checks = 0;
    int    errors = 0;
    int    pushes [2] = '{0, 0};
    int    pops   [2] = '{0, 0};
    int    ovs_pulses = 0;
    logic [4:0] ovs_occ = '0;

    always #5 aclk = ~aclk;

    axis_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(16), .PACKET_MODE(0)) dut_ct (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]), .s_axis_tdata(s_data[0]),
        .s_axis_tkeep(s_keep[0]), .s_axis_tlast(s_last[0]),
        .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]), .m_axis_tdata(m_data[0]),
        .m_axis_tkeep(m_keep[0]), .m_axis_tlast(m_last[0]),
        .occupancy(occ[0]), .almost_full(af[0]), .almost_empty(ae[0]), .pkt_oversize(ovs[0])
    );

    axis_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(16), .PACKET_MODE(1)) dut_pk (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]), .s_axis_tdata(s_data[1]),
        .s_axis_tkeep(s_keep[1]), .s_axis_tlast(s_last[1]),
        .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]), .m_axis_tdata(m_data[1]),
        .m_axis_tkeep(m_keep[1]), .m_axis_tlast(m_last[1]),
        .occupancy(occ[1]), .almost_full(af[1]), .almost_empty(ae[1]), .pkt_oversize(ovs[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Pop is scored before push: a beat cannot leave in the cycle it arrives
    task automatic scoreDut(input int k);
        beat_t got;
        beat_t exp_beat;
        if (m_valid[k] && m_ready[k]) begin
            got = {m_data[k], m_keep[k], m_last[k]};
            pops[k]++;
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                checkOutput($sformatf("dut%0d_unexpected_beat", k), 32'(got), 32'hFFFF_FFFF);
            end else begin
                if (k == 0) exp_beat = q0.pop_front();
                else        exp_beat = q1.pop_front();
                checkOutput($sformatf("dut%0d_beat", k), 32'(got), 32'(exp_beat));
            end
        end
        if (s_valid[k] && s_ready[k]) begin
            pushes[k]++;
            if (k == 0) q0.push_back({s_data[k], s_keep[k], s_last[k]});
            else        q1.push_back({s_data[k], s_keep[k], s_last[k]});
        end
        if (k == 1 && ovs[1]) begin
            ovs_pulses++;
            ovs_occ = occ[1];
        end
    endtask

    // Inputs are set at a falling edge; sample 1 time unit later, then cross one rising edge
    task automatic applyStimulus();
        #1;
        scoreDut(0);
        scoreDut(1);
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0;
            s_data[k]  = '0;
            s_keep[k]  = '0;
            s_last[k]  = 1'b0;
            m_ready[k] = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int exp_acc;
        int sent;
        int guard;

        idle();
        @(negedge aclk);
        @(negedge aclk);
        checkOutput("rst_s_ready", s_ready[0], 0);
        checkOutput("rst_m_valid", m_valid[0], 0);
        checkOutput("rst_m_valid_pk", m_valid[1], 0);
        checkOutput("rst_af", af[0], 0);
        checkOutput("rst_ae", ae[0], 1);
        checkOutput("rst_occ", occ[0], 0);
        checkOutput("rst_ovs", ovs[1], 0);
        aresetn = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        checkOutput("post_rst_ready_ct", s_ready[0], 1);
        checkOutput("post_rst_ready_pk", s_ready[1], 1);

        // Fill: 20 offered beats, no consumer
        for (int i = 0; i < 20; i++) begin
            s_valid[0] = 1'b1;
            s_data[0]  = 8'(i);
            s_keep[0]  = 1'(i % 2);
            s_last[0]  = (i % 4 == 3);
            applyStimulus();
            exp_acc = (i + 1 > 16) ? 16 : i + 1;
            checkOutput("fill_occ", occ[0], exp_acc);
            checkOutput("fill_af", af[0], (exp_acc >= 14));
        end
        checkOutput("fill_accepted", pushes[0], 16);
        checkOutput("fill_s_ready", s_ready[0], 0);
        checkOutput("fill_m_valid", m_valid[0], 1);

        // Drain: 16 beats back-to-back
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b1;
        base = pops[0];
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            checkOutput("drain_count", pops[0] - base, i + 1);
        end
        checkOutput("drain_m_valid", m_valid[0], 0);
        checkOutput("drain_occ", occ[0], 0);
        checkOutput("drain_ae", ae[0], 1);
        checkOutput("drain_queue", q0.size(), 0);

        // Streaming at occupancy 8 across pointer wrap
        m_ready[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_valid[0] = 1'b1;
            s_data[0]  = 8'(100 + i);
            s_keep[0]  = 1'b1;
            s_last[0]  = 1'b0;
            applyStimulus();
        end
        checkOutput("stream_pre_occ", occ[0], 8);
        m_ready[0] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_data[0] = 8'(200 + i);
            s_keep[0] = 1'(i % 3 != 0);
            s_last[0] = (i % 5 == 4);
            applyStimulus();
            checkOutput("stream_occ", occ[0], 8);
        end
        s_valid[0] = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus();
        checkOutput("stream_queue", q0.size(), 0);
        checkOutput("stream_end_occ", occ[0], 0);
        idle();

        // Packet mode: 5-beat packet with gaps, nothing out until tlast accepted
        m_ready[1] = 1'b1;
        base = pops[1];
        for (int i = 0; i < 10; i++) begin
            s_valid[1] = (i % 2 == 0);
            s_data[1]  = 8'(8'h11 + i / 2);
            s_keep[1]  = 1'b1;
            s_last[1]  = (i == 8);
            #1;
            checkOutput("pkt_hold", m_valid[1], (i > 8));
            #0;
            applyStimulus();
        end
        s_valid[1] = 1'b0;
        s_last[1]  = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus();
        checkOutput("pkt_count", pops[1] - base, 5);
        checkOutput("pkt_queue", q1.size(), 0);
        checkOutput("pkt_idle", m_valid[1], 0);

        // Oversize: 20-beat packet into a 16-deep store-and-forward buffer
        base  = pushes[1];
        sent  = 0;
        guard = 0;
        while (sent < 20 && guard < 80) begin
            s_valid[1] = 1'b1;
            s_data[1]  = 8'(8'h40 + sent);
            s_keep[1]  = 1'b1;
            s_last[1]  = (sent == 19);
            applyStimulus();
            sent = pushes[1] - base;
            guard++;
        end
        checkOutput("ovs_sent", sent, 20);
        s_valid[1] = 1'b0;
        s_last[1]  = 1'b0;
        guard = 0;
        while (q1.size() != 0 && guard < 40) begin
            applyStimulus();
            guard++;
        end
        checkOutput("ovs_drained", q1.size(), 0);
        checkOutput("ovs_pulses", ovs_pulses, 1);
        checkOutput("ovs_pulse_occ", ovs_occ, 16);

        // Release must have cleared: a lone non-last beat is held again
        s_valid[1] = 1'b1;
        s_data[1]  = 8'h77;
        applyStimulus();
        s_valid[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("ovs_release_cleared", m_valid[1], 0);
            applyStimulus();
        end
        s_valid[1] = 1'b1;
        s_data[1]  = 8'h78;
        s_last[1]  = 1'b1;
        applyStimulus();
        idle();
        m_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("ovs_tail_queue", q1.size(), 0);
        idle();

        // Mid-operation reset at occupancy 9
        for (int i = 0; i < 9; i++) begin
            s_valid[0] = 1'b1;
            s_data[0]  = 8'(8'h90 + i);
            s_keep[0]  = 1'b1;
            applyStimulus();
        end
        s_valid[0] = 1'b0;
        checkOutput("mid_occ", occ[0], 9);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("mid_rst_m_valid", m_valid[0], 0);
        checkOutput("mid_rst_occ", occ[0], 0);
        checkOutput("mid_rst_s_ready", s_ready[0], 0);
        q0.delete();
        q1.delete();
        @(negedge aclk);
        aresetn = 1'b1;
        m_ready[0] = 1'b1;
        base = pops[0];
        applyStimulus();
        s_valid[0] = 1'b1;
        s_data[0]  = 8'hA5;
        s_keep[0]  = 1'b0;
        s_last[0]  = 1'b1;
        applyStimulus();
        s_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("mid_new_pops", pops[0] - base, 1);
        checkOutput("mid_queue", q0.size(), 0);
        checkOutput("mid_final_occ", occ[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
